sfx_sequencer: RTL and testbench



---
 rtl/sfx_pkg.sv | 35 +++
 rtl/sfx_note_rom.sv | 31 +++
 rtl/sfx_sequencer.sv | 121 ++++++++++++
 tb/tb_sfx_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect sequencer.
package sfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } sfx_state_t;

  // Higher value wins; PRI_NONE doubles as "no trigger this cycle".
  typedef logic [1:0] sfx_pri_t;
  localparam sfx_pri_t PRI_NONE     = 2'd0;
  localparam sfx_pri_t PRI_MISS     = 2'd1;
  localparam sfx_pri_t PRI_SCORE    = 2'd2;
  localparam sfx_pri_t PRI_GAMEOVER = 2'd3;

  localparam logic [3:0] SFX_SCORE_BASE    = 4'd0;
  localparam logic [3:0] SFX_MISS_BASE     = 4'd4;
  localparam logic [3:0] SFX_GAMEOVER_BASE = 4'd8;

  // One ROM word: tone code and duration in note units (len 0 = end).
  typedef struct packed {
    logic [3:0] tone;
    logic [3:0] len;
  } note_t;

  function automatic logic [3:0] sfx_base(input sfx_pri_t p);
    case (p)
      PRI_GAMEOVER: return SFX_GAMEOVER_BASE;
      PRI_SCORE:    return SFX_SCORE_BASE;
      default:      return SFX_MISS_BASE;
    endcase
  endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// Melody table: combinational lookup of {tone, len} by address.
module sfx_note_rom
  import sfx_pkg::*;
#(
  parameter int ROM_AW = 4
) (
  input  logic [ROM_AW-1:0] addr,
  output note_t             note
);

  // Unlisted addresses read as end markers.
  always_comb begin
    note = '0;
    case (addr)
      // score
      ROM_AW'(0):  note = {4'd4,  4'd2};
      ROM_AW'(1):  note = {4'd6,  4'd2};
      ROM_AW'(2):  note = {4'd8,  4'd4};
      // miss
      ROM_AW'(4):  note = {4'd12, 4'd3};
      ROM_AW'(5):  note = {4'd15, 4'd5};
      // game over
      ROM_AW'(8):  note = {4'd8,  4'd4};
      ROM_AW'(9):  note = {4'd10, 4'd4};
      ROM_AW'(10): note = {4'd12, 4'd4};
      ROM_AW'(11): note = {4'd15, 4'd8};
      default:     note = '0;
    endcase
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Plays fixed ROM melodies on the tone generator's sound-select bus in
// response to one-cycle game event triggers.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int NOTE_UNIT = 50,
  parameter int ROM_AW    = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       trig_score,
  input  logic       trig_miss,
  input  logic       trig_gameover,
  input  logic       mute,
  output logic [3:0] sound_select,
  output logic       busy,
  output logic       done
);

  // Guard against zero-width counters for degenerate divider settings.
  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int TW = (NOTE_UNIT > 1) ? $clog2(NOTE_UNIT) : 1;

  sfx_state_t        state;
  sfx_pri_t          cur_pri;
  sfx_pri_t          new_pri;
  logic              accept;
  logic [ROM_AW-1:0] addr;
  logic [PW-1:0]     presc;
  logic [TW-1:0]     tiu;
  logic [3:0]        unit_cnt;
  logic [3:0]        tone_q;
  logic              presc_wrap;
  logic              tiu_wrap;
  note_t             note;

  sfx_note_rom #(.ROM_AW(ROM_AW)) u_rom (
    .addr (addr),
    .note (note)
  );

  // Pick the highest simultaneous trigger; take it unless a stronger effect plays.
  always_comb begin
    new_pri = PRI_NONE;
    if (trig_gameover)   new_pri = PRI_GAMEOVER;
    else if (trig_score) new_pri = PRI_SCORE;
    else if (trig_miss)  new_pri = PRI_MISS;
    accept = (new_pri != PRI_NONE) && ((state == ST_IDLE) || (new_pri >= cur_pri));
  end

  assign presc_wrap = (presc == PW'(TICK_DIV - 1));
  assign tiu_wrap   = (tiu   == TW'(NOTE_UNIT - 1));

  // Mute only masks the output; the melody keeps running underneath.
  assign sound_select = mute ? 4'd0 : tone_q;

  // Sequencer FSM: fetch a note, hold it for len units, advance, stop on end marker.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cur_pri  <= PRI_NONE;
      addr     <= '0;
      presc    <= '0;
      tiu      <= '0;
      unit_cnt <= '0;
      tone_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Preemption keeps the old tone through FETCH and never pulses done.
        state   <= ST_FETCH;
        addr    <= ROM_AW'(sfx_base(new_pri));
        cur_pri <= new_pri;
        busy    <= 1'b1;
        presc   <= '0;
        tiu     <= '0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_FETCH: begin
            if (note.len == 4'd0) begin
              state   <= ST_IDLE;
              cur_pri <= PRI_NONE;
              tone_q  <= 4'd0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state    <= ST_PLAY;
              tone_q   <= note.tone;
              unit_cnt <= note.len;
              presc    <= '0;
              tiu      <= '0;
            end
          end
          ST_PLAY: begin
            if (presc_wrap) begin
              presc <= '0;
              if (tiu_wrap) begin
                tiu      <= '0;
                unit_cnt <= unit_cnt - 4'd1;
                if (unit_cnt == 4'd1) begin
                  addr  <= addr + 1'b1;
                  state <= ST_FETCH;
                end
              end else begin
                tiu <= tiu + 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with a melody-level reference model.
module tb_sfx_sequencer;

  localparam int TICK_DIV  = 10;
  localparam int NOTE_UNIT = 2;
  localparam int UNIT      = TICK_DIV * NOTE_UNIT;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       trig_score = 1'b0, trig_miss = 1'b0, trig_gameover = 1'b0;
  logic       mute = 1'b0;
  logic [3:0] sound_select;
  logic       busy, done;

  sfx_sequencer #(.TICK_DIV(TICK_DIV), .NOTE_UNIT(NOTE_UNIT), .ROM_AW(4)) dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .trig_score    (trig_score),
    .trig_miss     (trig_miss),
    .trig_gameover (trig_gameover),
    .mute          (mute),
    .sound_select  (sound_select),
    .busy          (busy),
    .done          (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0, failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Melodies by effect index: 0 score, 1 miss, 2 game over.
  int mel_tone [3][5] = '{'{4, 6, 8, 0, 0}, '{12, 15, 0, 0, 0}, '{8, 10, 12, 15, 0}};
  int mel_len  [3][5] = '{'{2, 2, 4, 0, 0}, '{3, 5, 0, 0, 0},   '{4, 4, 4, 8, 0}};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // Edges from acceptance to the end edge: one FETCH, then each note for len units + its trailing fetch.
  function automatic int total_of(input int eff);
    int t = 1;
    for (int i = 0; i < 5; i++) begin
      if (mel_len[eff][i] == 0) break;
      t += mel_len[eff][i] * UNIT + 1;
    end
    return t;
  endfunction

  // Tone heard e edges after acceptance (e >= 1).
  function automatic int tone_at(input int eff, input int e);
    int acc = 1;
    for (int i = 0; i < 5; i++) begin
      if (mel_len[eff][i] == 0) return 0;
      if (e < acc + mel_len[eff][i] * UNIT + 1) return mel_tone[eff][i];
      acc += mel_len[eff][i] * UNIT + 1;
    end
    return 0;
  endfunction

  int m_active = 0, m_pri = 0, m_eff = 0, m_start = 0, m_total = 0, m_hold = 0;
  int e_tone = 0, e_busy = 0, e_done = 0;

  // Reference model advanced per edge, then compared with the DUT just after the edge.
  always @(posedge CLOCK_50) begin
    int np, ne;
    bit ending;
    cyc++;
    if (!resetn) begin
      m_active = 0; m_pri = 0; e_tone = 0; e_busy = 0; e_done = 0;
    end else begin
      ending = (m_active != 0) && (cyc - m_start == m_total);
      np = trig_gameover ? 3 : trig_score ? 2 : trig_miss ? 1 : 0;
      ne = trig_gameover ? 2 : trig_score ? 0 : 1;
      e_done = 0;
      if (np != 0 && (m_active == 0 || np >= m_pri)) begin
        m_hold = e_tone;
        m_active = 1; m_pri = np; m_eff = ne; m_start = cyc;
        m_total = total_of(ne);
        e_tone = m_hold; e_busy = 1;
      end else if (ending) begin
        m_active = 0; m_pri = 0; e_tone = 0; e_busy = 0; e_done = 1;
      end else if (m_active != 0) begin
        e_tone = tone_at(m_eff, cyc - m_start);
        e_busy = 1;
      end
    end
    #1;
    chk("model_sound", int'(sound_select), mute ? 0 : e_tone);
    chk("model_busy",  int'(busy), e_busy);
    chk("model_done",  int'(done), e_done);
    if (done) done_cnt++;
  end

  // Drive trigger bits for exactly one sampling edge; n is that edge's number.
  task automatic pulse(input bit s, input bit m, input bit g, output int n);
    @(negedge CLOCK_50);
    trig_score = s; trig_miss = m; trig_gameover = g;
    @(negedge CLOCK_50);
    trig_score = 0; trig_miss = 0; trig_gameover = 0;
    n = cyc;
  endtask

  task automatic at_edge(input int k);
    while (cyc < k) @(negedge CLOCK_50);
  endtask

  initial begin
    int n, g, dc0;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    chk("reset_sound", int'(sound_select), 0);
    chk("reset_busy",  int'(busy), 0);
    chk("reset_done",  int'(done), 0);
    repeat (100) @(negedge CLOCK_50);

    // Score melody with literal note boundaries.
    dc0 = done_cnt;
    pulse(1, 0, 0, n);
    chk("score_fetch_silent", int'(sound_select), 0);
    at_edge(n + 1);   chk("score_n1",   int'(sound_select), 4);
    at_edge(n + 41);  chk("score_n1_end", int'(sound_select), 4);
    at_edge(n + 42);  chk("score_n2",   int'(sound_select), 6);
    at_edge(n + 83);  chk("score_n3",   int'(sound_select), 8);
    at_edge(n + 163); chk("score_busy_last", int'(busy), 1);
    at_edge(n + 164); chk("score_done", int'(done), 1);
    chk("score_busy_fall", int'(busy), 0);
    chk("score_silent", int'(sound_select), 0);
    at_edge(n + 170); chk("score_done_count", done_cnt - dc0, 1);

    // Miss preempted by game over 30 cycles in.
    dc0 = done_cnt;
    pulse(0, 1, 0, n);
    at_edge(n + 29);
    pulse(0, 0, 1, g);
    chk("preempt_fetch_hold", int'(sound_select), 12);
    at_edge(g + 1);   chk("preempt_go_n1", int'(sound_select), 8);
    at_edge(g + 82);  chk("preempt_go_n2", int'(sound_select), 10);
    at_edge(g + 163); chk("preempt_go_n3", int'(sound_select), 12);
    at_edge(g + 244); chk("preempt_go_n4", int'(sound_select), 15);
    at_edge(g + 404); chk("preempt_go_n4_end", int'(sound_select), 15);
    at_edge(g + 405); chk("preempt_done", int'(done), 1);
    at_edge(g + 410); chk("preempt_done_count", done_cnt - dc0, 1);

    // Lower-priority score ignored during game over.
    pulse(0, 0, 1, g);
    at_edge(g + 100);
    pulse(1, 0, 0, n);
    chk("ignore_tone", int'(sound_select), 10);
    at_edge(g + 405); chk("ignore_done_on_time", int'(done), 1);
    at_edge(g + 410);

    // Simultaneous score + miss from idle starts score.
    pulse(1, 1, 0, n);
    at_edge(n + 1);   chk("simul_score", int'(sound_select), 4);
    at_edge(n + 170);

    // Muted score: silent, timing unchanged.
    mute = 1'b1;
    dc0 = done_cnt;
    pulse(1, 0, 0, n);
    at_edge(n + 1);   chk("mute_silent", int'(sound_select), 0);
    chk("mute_busy", int'(busy), 1);
    at_edge(n + 163); chk("mute_busy_last", int'(busy), 1);
    at_edge(n + 164); chk("mute_done", int'(done), 1);
    chk("mute_busy_fall", int'(busy), 0);
    at_edge(n + 170); chk("mute_done_count", done_cnt - dc0, 1);
    mute = 1'b0;

    // Asynchronous reset mid-note, then a normal miss.
    pulse(0, 1, 0, n);
    at_edge(n + 10);  chk("prereset_tone", int'(sound_select), 12);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_sound", int'(sound_select), 0);
    chk("async_rst_busy",  int'(busy), 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    pulse(0, 1, 0, n);
    at_edge(n + 1);   chk("post_rst_n1", int'(sound_select), 12);
    at_edge(n + 62);  chk("post_rst_n2", int'(sound_select), 15);
    at_edge(n + 163); chk("post_rst_done", int'(done), 1);
    chk("post_rst_silent", int'(sound_select), 0);
    at_edge(n + 170);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
